program_sequencer: RTL and testbench

Fetch/issue controller that sequences the `ExecutionUnit` datapath. It owns the program counter and fetches 12-bit instructions from the SPI-loaded program ROM over a request/valid handshake. Each instruction is presented to the execution unit as `opcode`/`operand` with a one-cycle `start` strobe. It also handles skip-next, halt, stop and address wrap-around, and sits between the ROM/SPI loader and the execution unit in the CPU top level.

---
 rtl/cpu_seq_pkg.sv | 29 ++
 rtl/program_sequencer_if.sv | 25 ++
 rtl/seq_pc.sv | 31 +++
 rtl/program_sequencer.sv | 135 +++++++++++++
 tb/tb_program_sequencer.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the program sequencer: state encoding, instruction
// field positions, the default halt opcode and the PC update command type.
package cpu_seq_pkg;

    localparam int ADDR_W_DEFAULT = 5;
    localparam int DATA_W_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [DATA_W_DEFAULT-1:0] HALT_OPCODE_DEFAULT = 4'hF;

    // Instruction word layout: opcode in the top nibble, operand below it.
    localparam int INSTR_W    = 3 * DATA_W_DEFAULT;
    localparam int OPCODE_HI  = 11;
    localparam int OPCODE_LO  = 8;
    localparam int OPERAND_HI = 7;
    localparam int OPERAND_LO = 0;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_CLEAR = 2'd1,
        PC_INC1  = 2'd2,
        PC_INC2  = 2'd3
    } pc_op_e;

endpackage

// File: rtl/program_sequencer_if.sv
// Fetch handshake to the program ROM plus the issue path to the execution
// unit; the sequencer drives through the master modport.
interface program_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic                  rom_req;
    logic [ADDR_W-1:0]     rom_addr;
    logic                  rom_valid;
    logic [3*DATA_W-1:0]   rom_data;
    logic [DATA_W-1:0]     opcode;
    logic [2*DATA_W-1:0]   operand;
    logic                  start;
    logic                  skip;

    modport master (
        output rom_req, rom_addr, opcode, operand, start,
        input  rom_valid, rom_data, skip
    );

    modport slave (
        input  rom_req, rom_addr, opcode, operand, start,
        output rom_valid, rom_data, skip
    );
endinterface

// File: rtl/seq_pc.sv
// Program counter register: clear, +1 or +2 per command, wrapping modulo
// 2^ADDR_W through natural truncation of the adder.
module seq_pc
    import cpu_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  pc_op_e            i_pc_op,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else begin
            case (i_pc_op)
                PC_CLEAR: r_pc <= '0;
                PC_INC1:  r_pc <= r_pc + ADDR_W'(1);
                PC_INC2:  r_pc <= r_pc + ADDR_W'(2);
                default:  r_pc <= r_pc;
            endcase
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/program_sequencer.sv
// Fetch/issue controller: walks the program ROM and strobes each instruction
// into the execution unit. Optional breakpoint support under SEQ_BREAKPOINT_EN.
module program_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int                          ROM_ADDRESS_WIDTH = ADDR_W_DEFAULT,
    parameter int                          INPUT_DATA_WIDTH  = DATA_W_DEFAULT,
    parameter logic [INPUT_DATA_WIDTH-1:0] HALT_OPCODE       = HALT_OPCODE_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         stop,
    program_sequencer_if.master          bus,
`ifdef SEQ_BREAKPOINT_EN
    input  logic                         bp_en,
    input  logic [ROM_ADDRESS_WIDTH-1:0] bp_addr,
`endif
    output logic [ROM_ADDRESS_WIDTH-1:0] pc,
    output logic                         busy,
    output logic                         halted,
    output logic                         bp_hit
);

    logic [1:0]                   r_state;
    logic [1:0]                   w_state_next;
    logic [INSTR_W-1:0]           r_ir;
    logic [ROM_ADDRESS_WIDTH-1:0] w_pc;
    pc_op_e                       w_pc_op;
    logic                         w_launch;
    logic                         w_capture;
    logic                         w_is_halt_word;
    logic                         w_bp_launch;
    logic                         w_bp_exec;

    // A run only counts when stop is not also asserted; stop always wins.
    assign w_launch       = ((r_state == ST_IDLE) || (r_state == ST_HALT)) && run && !stop;
    assign w_capture      = (r_state == ST_FETCH) && bus.rom_valid && !stop;
    assign w_is_halt_word = (bus.rom_data[OPCODE_HI:OPCODE_LO] == HALT_OPCODE);

`ifdef SEQ_BREAKPOINT_EN
    logic [ROM_ADDRESS_WIDTH-1:0] w_pc_after_exec;
    logic                         r_bp_hit;

    // The breakpoint is judged against the address FETCH would start at, so
    // the redirect to HALT happens before any request goes out.
    assign w_pc_after_exec = w_pc + (bus.skip ? ROM_ADDRESS_WIDTH'(2) : ROM_ADDRESS_WIDTH'(1));
    assign w_bp_launch     = bp_en && (bp_addr == '0);
    assign w_bp_exec       = bp_en && (bp_addr == w_pc_after_exec);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bp_hit <= 1'b0;
        end else if (w_launch) begin
            r_bp_hit <= w_bp_launch;
        end else if ((r_state == ST_EXEC) && !stop && w_bp_exec) begin
            r_bp_hit <= 1'b1;
        end
    end

    assign bp_hit = r_bp_hit;
`else
    assign w_bp_launch = 1'b0;
    assign w_bp_exec   = 1'b0;
    assign bp_hit      = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (run) begin
                    w_state_next = w_bp_launch ? ST_HALT : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (bus.rom_valid) begin
                    w_state_next = w_is_halt_word ? ST_HALT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = w_bp_exec ? ST_HALT : ST_FETCH;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pc_op = PC_HOLD;
        if (w_launch) begin
            w_pc_op = PC_CLEAR;
        end else if (r_state == ST_EXEC) begin
            w_pc_op = bus.skip ? PC_INC2 : PC_INC1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_ir <= bus.rom_data;
            end
        end
    end

    seq_pc #(
        .ADDR_W (ROM_ADDRESS_WIDTH)
    ) u_seq_pc (
        .clk     (clk),
        .reset   (reset),
        .i_pc_op (w_pc_op),
        .o_pc    (w_pc)
    );

    assign bus.rom_req  = (r_state == ST_FETCH);
    assign bus.rom_addr = w_pc;
    assign bus.start    = (r_state == ST_EXEC);
    assign bus.opcode   = r_ir[OPCODE_HI:OPCODE_LO];
    assign bus.operand  = r_ir[OPERAND_HI:OPERAND_LO];
    assign pc           = w_pc;
    assign busy         = (r_state == ST_FETCH) || (r_state == ST_EXEC);
    assign halted       = (r_state == ST_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a ROM/execution-unit responder,
// an issue monitor and a program-walk reference model.
module tb_program_sequencer;
    import cpu_seq_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          stop;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          bp_hit;
`ifdef SEQ_BREAKPOINT_EN
    logic          bp_en;
    logic [AW-1:0] bp_addr;
    bit            req_seen [DEPTH];
`endif

    program_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) dut_if ();

    program_sequencer #(
        .ROM_ADDRESS_WIDTH (AW),
        .INPUT_DATA_WIDTH  (DW),
        .HALT_OPCODE       (4'hF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .stop    (stop),
        .bus     (dut_if),
`ifdef SEQ_BREAKPOINT_EN
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
`endif
        .pc      (pc),
        .busy    (busy),
        .halted  (halted),
        .bp_hit  (bp_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        int         cyc;
        logic [3:0] opc;
        logic [7:0] opr;
    } issue_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [11:0] mem [DEPTH];
    bit          skip_map [DEPTH];
    int          wait_mode = 0;
    int          wait_cnt = 0;
    int          cur_wait = 0;
    issue_t      issued [$];
    int          exp_addr [$];
    bit          exp_bp_halt;
    int          addr_pc_err = 0;
    int          halt_issue_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM with programmable wait states and an execution unit that raises
    // skip per address; both inputs carry noise when they must be ignored.
    always @(negedge clk) begin
        if (dut_if.rom_req) begin
            if (wait_cnt < cur_wait) begin
                dut_if.rom_valid = 1'b0;
                wait_cnt++;
            end else begin
                dut_if.rom_valid = 1'b1;
            end
        end else begin
            dut_if.rom_valid = 1'b0;
            wait_cnt = 0;
            cur_wait = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
        end
        dut_if.rom_data = dut_if.rom_valid ? mem[dut_if.rom_addr] : 12'($urandom);
        dut_if.skip     = dut_if.start ? skip_map[pc] : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (dut_if.start) begin
            issued.push_back('{int'(pc), cyc, dut_if.opcode, dut_if.operand});
            $display("[%0t] issue addr=%0d opcode=%h operand=%h", $time, pc, dut_if.opcode, dut_if.operand);
        end
        if (dut_if.rom_addr !== pc) addr_pc_err++;
        if (dut_if.start && dut_if.opcode == 4'hF) halt_issue_err++;
`ifdef SEQ_BREAKPOINT_EN
        if (dut_if.rom_req) req_seen[dut_if.rom_addr] = 1'b1;
`endif
    end

    // Walk the program by the architectural rules: halt word or breakpoint
    // ends it, otherwise issue and advance by one or two, modulo the ROM size.
    task automatic model_program(input int bp);
        int a = 0;
        exp_addr.delete();
        exp_bp_halt = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (a == bp) begin
                exp_bp_halt = 1'b1;
                break;
            end
            if (mem[a][11:8] == 4'hF) break;
            exp_addr.push_back(a);
            a = (a + (skip_map[a] ? 2 : 1)) % DEPTH;
        end
    endtask

    task automatic fill_plain(input int upto);
        for (int a = 0; a < DEPTH; a++) begin
            mem[a]      = {4'($urandom_range(0, 14)), 8'($urandom)};
            skip_map[a] = 1'b0;
        end
        if (upto < DEPTH) mem[upto] = {4'hF, 8'($urandom)};
    endtask

    task automatic run_program(output int c0);
        @(negedge clk);
        issued.delete();
`ifdef SEQ_BREAKPOINT_EN
        foreach (req_seen[i]) req_seen[i] = 1'b0;
`endif
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_halted(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pc, dut_if.opcode, dut_if.operand} !== '0) begin
            errors++;
            $display("FAIL reset_regs pc=%0d opcode=%h operand=%h required 0", pc, dut_if.opcode, dut_if.operand);
        end
        checks++;
        if ({dut_if.start, dut_if.rom_req, busy, halted, bp_hit} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags start/req/busy/halted/bp=%b required 00000",
                     {dut_if.start, dut_if.rom_req, busy, halted, bp_hit});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_run busy=%b required 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait();
        int  c0;
        bit  exp_s;
        fill_plain(3);
        mem[0][11:8] = 4'h1;
        mem[1][11:8] = 4'h2;
        mem[2][11:8] = 4'h3;
        wait_mode = 0;
        run_program(c0);
        checks++;
        if (!(busy === 1'b1 && dut_if.rom_req === 1'b1 && dut_if.rom_addr === 5'd0)) begin
            errors++;
            $display("FAIL zw_cycle1 busy=%b req=%b addr=%0d required 1 1 0", busy, dut_if.rom_req, dut_if.rom_addr);
        end
        for (int n = 2; n <= 8; n++) begin
            @(negedge clk);
            exp_s = (n == 2 || n == 4 || n == 6);
            checks++;
            if (dut_if.start !== exp_s) begin
                errors++;
                $display("FAIL zw_start cycle=%0d start=%b required %b", n, dut_if.start, exp_s);
            end
            if (exp_s) begin
                checks++;
                if ({dut_if.opcode, dut_if.operand} !== mem[n/2-1]) begin
                    errors++;
                    $display("FAIL zw_instr cycle=%0d got=%h required %h", n, {dut_if.opcode, dut_if.operand}, mem[n/2-1]);
                end
            end
            checks++;
            if (halted !== (n >= 8)) begin
                errors++;
                $display("FAIL zw_halted cycle=%0d halted=%b required %b", n, halted, (n >= 8));
            end
        end
        $display("test_zero_wait done");
    endtask

    task automatic test_skip();
        int c0;
        bit ok;
        bit saw5 = 1'b0;
        fill_plain(8);
        skip_map[4] = 1'b1;
        wait_mode = 0;
        model_program(-1);
        run_program(c0);
        wait_halted(100, ok);
        checks++;
        if (!ok || issued.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL skip_count halted=%b issued=%0d required %0d", ok, issued.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[k]) begin
                checks++;
                if (issued[k].addr != exp_addr[k] || {issued[k].opc, issued[k].opr} !== mem[exp_addr[k]]) begin
                    errors++;
                    $display("FAIL skip_issue k=%0d addr=%0d word=%h required addr=%0d word=%h",
                             k, issued[k].addr, {issued[k].opc, issued[k].opr}, exp_addr[k], mem[exp_addr[k]]);
                end
            end
        end
        foreach (issued[k]) if (issued[k].addr == 5) saw5 = 1'b1;
        checks++;
        if (saw5) begin
            errors++;
            $display("FAIL skip_addr5 issued=1 required 0");
        end
        $display("test_skip done");
    endtask

    task automatic test_random_program();
        int c0;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a]      = {($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 8'($urandom)};
                skip_map[a] = ($urandom_range(0, 3) == 0);
            end
            mem[30][11:8] = 4'hF;
            mem[31][11:8] = 4'hF;
            wait_mode = (it % 2 == 0) ? 0 : -1;
            model_program(-1);
            run_program(c0);
            wait_halted(600, ok);
            checks++;
            if (!ok || issued.size() != exp_addr.size()) begin
                errors++;
                $display("FAIL rand_count it=%0d halted=%b issued=%0d required %0d", it, ok, issued.size(), exp_addr.size());
                continue;
            end
            foreach (exp_addr[k]) begin
                checks++;
                if (issued[k].addr != exp_addr[k] || {issued[k].opc, issued[k].opr} !== mem[exp_addr[k]]) begin
                    errors++;
                    $display("FAIL rand_issue it=%0d k=%0d addr=%0d word=%h required addr=%0d word=%h", it, k,
                             issued[k].addr, {issued[k].opc, issued[k].opr}, exp_addr[k], mem[exp_addr[k]]);
                end
                if (wait_mode == 0) begin
                    checks++;
                    if (issued[k].cyc - c0 + 1 != 2 * (k + 1)) begin
                        errors++;
                        $display("FAIL rand_timing it=%0d k=%0d cycle=%0d required %0d", it, k,
                                 issued[k].cyc - c0 + 1, 2 * (k + 1));
                    end
                end
            end
        end
        $display("test_random_program done");
    endtask

    task automatic test_wrap();
        int          c0;
        bit          found;
        int          target;
        logic [AW-1:0] exp_next;
        fill_plain(DEPTH);
        wait_mode = 0;
        for (int cs = 0; cs < 3; cs++) begin
            foreach (skip_map[a]) skip_map[a] = 1'b0;
            target   = (cs == 2) ? 30 : 31;
            exp_next = (cs == 0) ? 5'd1 : 5'd0;
            if (cs != 1) skip_map[target] = 1'b1;
            run_program(c0);
            found = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (dut_if.start && pc == 5'(target)) begin
                    found = 1'b1;
                    break;
                end
            end
            @(negedge clk);
            checks++;
            if (!found || dut_if.rom_req !== 1'b1 || dut_if.rom_addr !== exp_next) begin
                errors++;
                $display("FAIL wrap_next case=%0d found=%b req=%b addr=%0d required addr %0d",
                         cs, found, dut_if.rom_req, dut_if.rom_addr, exp_next);
            end
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            checks++;
            if (busy !== 1'b0 || pc !== exp_next || dut_if.start !== 1'b0) begin
                errors++;
                $display("FAIL wrap_stop case=%0d busy=%b pc=%0d start=%b required 0 %0d 0",
                         cs, busy, pc, dut_if.start, exp_next);
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_stall_stop();
        int c0;
        fill_plain(DEPTH);
        wait_mode = 3;
        run_program(c0);
        for (int n = 1; n <= 4; n++) begin
            if (n > 1) @(negedge clk);
            checks++;
            if (dut_if.rom_req !== 1'b1 || dut_if.rom_addr !== 5'd0 || dut_if.start !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d req=%b addr=%0d start=%b required 1 0 0",
                         n, dut_if.rom_req, dut_if.rom_addr, dut_if.start);
            end
        end
        @(negedge clk);
        checks++;
        if (dut_if.start !== 1'b1) begin
            errors++;
            $display("FAIL stall_start cycle=5 start=%b required 1", dut_if.start);
        end
        @(negedge clk);
        checks++;
        if (dut_if.rom_req !== 1'b1 || dut_if.rom_addr !== 5'd1) begin
            errors++;
            $display("FAIL stall_fetch2 req=%b addr=%0d required 1 1", dut_if.rom_req, dut_if.rom_addr);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || dut_if.rom_req !== 1'b0 || pc !== 5'd1 || dut_if.start !== 1'b0) begin
            errors++;
            $display("FAIL stall_stop busy=%b req=%b pc=%0d start=%b required 0 0 1 0",
                     busy, dut_if.rom_req, pc, dut_if.start);
        end
        run  = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        run  = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || pc !== 5'd1) begin
            errors++;
            $display("FAIL run_stop_idle busy=%b pc=%0d required 0 1", busy, pc);
        end
        wait_mode = 0;
        run_program(c0);
        @(negedge clk);
        checks++;
        if (dut_if.start !== 1'b1) begin
            errors++;
            $display("FAIL exec_stop_start start=%b required 1", dut_if.start);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || pc !== 5'd1) begin
            errors++;
            $display("FAIL exec_stop busy=%b halted=%b pc=%0d required 0 0 1", busy, halted, pc);
        end
        $display("test_stall_stop done");
    endtask

    task automatic test_reset_mid_exec();
        int c0;
        bit found = 1'b0;
        fill_plain(DEPTH);
        wait_mode = 0;
        run_program(c0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dut_if.start && pc == 5'd3) begin
                found = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (!found || {dut_if.start, dut_if.rom_req, busy, halted} !== 4'b0 || pc !== 5'd0) begin
            errors++;
            $display("FAIL reset_exec found=%b start/req/busy/halted=%b pc=%0d required 0000 0",
                     found, {dut_if.start, dut_if.rom_req, busy, halted}, pc);
        end
        run_program(c0);
        checks++;
        if (dut_if.rom_req !== 1'b1 || dut_if.rom_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_refetch req=%b addr=%0d required 1 0", dut_if.rom_req, dut_if.rom_addr);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        $display("test_reset_mid_exec done");
    endtask

`ifdef SEQ_BREAKPOINT_EN
    task automatic test_breakpoint();
        int c0;
        bit ok;
        fill_plain(8);
        wait_mode = 0;
        bp_en     = 1'b1;
        bp_addr   = 5'd3;
        model_program(3);
        run_program(c0);
        wait_halted(100, ok);
        checks++;
        if (!ok || issued.size() != exp_addr.size() || bp_hit !== exp_bp_halt) begin
            errors++;
            $display("FAIL bp_halt halted=%b issued=%0d bp_hit=%b required 1 %0d %b",
                     ok, issued.size(), bp_hit, exp_addr.size(), exp_bp_halt);
        end else begin
            foreach (exp_addr[k]) begin
                checks++;
                if (issued[k].addr != exp_addr[k]) begin
                    errors++;
                    $display("FAIL bp_issue k=%0d addr=%0d required %0d", k, issued[k].addr, exp_addr[k]);
                end
            end
        end
        checks++;
        if (req_seen[3]) begin
            errors++;
            $display("FAIL bp_no_request requested=1 required 0");
        end
        bp_en = 1'b0;
        run_program(c0);
        checks++;
        if (bp_hit !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_clear bp_hit=%b busy=%b required 0 1", bp_hit, busy);
        end
        wait_halted(100, ok);
        $display("test_breakpoint done");
    endtask
`endif

    task automatic test_invariants();
        checks++;
        if (addr_pc_err != 0) begin
            errors++;
            $display("FAIL addr_eq_pc mismatching_cycles=%0d required 0", addr_pc_err);
        end
        checks++;
        if (halt_issue_err != 0) begin
            errors++;
            $display("FAIL halt_not_issued issues=%0d required 0", halt_issue_err);
        end
    endtask

    initial begin
        reset            = 1'b1;
        run              = 1'b0;
        stop             = 1'b0;
        dut_if.rom_valid = 1'b0;
        dut_if.rom_data  = '0;
        dut_if.skip      = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
        bp_en            = 1'b0;
        bp_addr          = '0;
`endif
        foreach (mem[a]) begin
            mem[a]      = '0;
            skip_map[a] = 1'b0;
        end
        test_reset();
        test_zero_wait();
        test_skip();
        test_random_program();
        test_wrap();
        test_stall_stop();
        test_reset_mid_exec();
`ifdef SEQ_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
